// File: rtl/dtc_vote_accum.sv
// dtc_vote_accum: windowed per-bit majority vote over a stream of classifier words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - synchronous flush of partial window and held result
//   in_valid/in_ready   - sample handshake, in_data carries the classifier word
//   out_valid/out_ready - result handshake, out_data = strict majority, out_tie = exact tie
module dtc_vote_accum #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_tie
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(WINDOW - 1);
  localparam logic [CMP_W-1:0] WIN_CMP   = CMP_W'(WINDOW);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q      [WIDTH];
  logic [CNT_W-1:0] cnt_inc_c  [WIDTH];
  logic [CMP_W-1:0] dbl_c      [WIDTH];
  logic [CNT_W-1:0] samp_cnt_q;
  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] maj_c;
  logic [WIDTH-1:0] tie_c;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  // clear suppresses any accept in the same cycle.
  assign accept_c = in_valid & in_ready & ~clear;
  assign last_c   = accept_c & (samp_cnt_q == LAST_SAMP);

  // Post-increment counts and the doubled-count vote (one extra bit so 2*count cannot wrap).
  always_comb begin
    maj_c = '0;
    tie_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_inc_c[i] = cnt_q[i] + CNT_W'(in_data[i]);
      dbl_c[i]     = {cnt_inc_c[i], 1'b0};
      maj_c[i]     = (dbl_c[i] > WIN_CMP);
      tie_c[i]     = (dbl_c[i] == WIN_CMP);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM:   if (last_c)    state_d = HOLD;
        HOLD:    if (out_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Counters and result registers; counters restart on the edge that closes a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q <= '0;
      out_data   <= '0;
      out_tie    <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else if (clear) begin
      samp_cnt_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        samp_cnt_q <= '0;
        out_data   <= maj_c;
        out_tie    <= tie_c;
        for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
        samp_cnt_q <= samp_cnt_q + CNT_W'(1);
        for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_inc_c[i];
      end
    end
  end

endmodule

// File: doc/dtc_vote_accum.md
# dtc_vote_accum

Streaming majority-vote accumulator that sits directly downstream of a `dtc_*` decision-tree classifier. It consumes the classifier's 8-bit output word one sample per handshake and keeps a per-bit population count over a window of WINDOW samples. At the end of each window it emits one registered majority-vote word plus a per-bit tie mask over a valid/ready handshake. It turns the classifier's per-sample combinational decisions into a debounced, windowed result for the next consumer.

## Interface
- `WIDTH`, 8: width of classifier output word and of all per-bit vectors.
- `WINDOW`, 8: samples per vote window; legal range 1..255.
- `CNT_W`, $clog2(WINDOW+1): width of each per-bit counter and of the sample counter (localparam).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush; discards the partial window and any held result.
- `in_valid` input 1: classifier sample present on `in_data`.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_data` input WIDTH: classifier output word.
- `out_valid` output 1: vote result held on `out_data`/`out_tie`.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output WIDTH: bit i = 1 iff count_i * 2 > WINDOW (strict majority).
- `out_tie` output WIDTH: bit i = 1 iff count_i * 2 == WINDOW (possible only for even WINDOW).

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - `in_ready` = 1 and `out_valid` = 0.
  - An accept is `in_valid & in_ready`. On each accept, every count_i increments where `in_data[i]` = 1, and `samp_cnt` increments.
  - If the accept brings `samp_cnt` to WINDOW, compute `out_data`/`out_tie` from the post-increment counts. Register them, clear all counters in the same edge, and go to HOLD.
- HOLD:
  - `in_ready` = 0. `out_valid` = 1. `out_data`/`out_tie` stay stable.
  - On `out_valid & out_ready`, go to ACCUM. The outputs may keep their last value, but `out_valid` drops.
- Counters never exceed WINDOW, so no saturation logic is needed. Comparisons use CNT_W+1 bits to avoid overflow of count*2.
- `clear`:
  - Zeroes all counters and `samp_cnt` and sets the state to ACCUM.
  - Discards any held result. `out_valid` = 0 next cycle.
  - A sample presented in the same cycle as `clear` is dropped.
  - `clear` has priority over every accept and handshake.
- `in_ready` is a function of state only and never depends on `in_valid`. `out_valid` comes straight from the state register and has no combinational path from `out_ready`.

## Timing
- Reset values:
  - State = ACCUM, counters = 0, `samp_cnt` = 0.
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_tie` = 0.
- Assertion of `rst_n` takes effect immediately (asynchronous). Deassertion is synchronized externally.
- Latency: the window's final sample is accepted at edge t. `out_valid` = 1 with the result from edge t (visible in cycle t+1).
- Throughput: the minimum window period is WINDOW + 1 cycles when `out_ready` is held high. The cycle spent in HOLD is a mandatory bubble on the input.
- Backpressure: HOLD persists for as long as `out_ready` = 0, and `in_ready` stays 0 throughout.
- WINDOW = 1: every accepted sample produces a result equal to `in_data`, with `out_tie` = 0.
- Reset mid-window or mid-HOLD: the partial window or held result is lost, and there is no spurious `out_valid`.

## Test plan
- Reset check: hold `rst_n` low, toggle inputs -> `out_valid` = 0, `in_ready` = 1, `out_data` = 8'h00 throughout; release -> first window starts at count 0.
- Clean majority: WINDOW = 8, feed 5× 8'hE9 and 3× 8'h30 with `out_ready` = 1 -> `out_valid` for exactly 1 cycle, `out_data` = 8'hE9, `out_tie` = 8'h00; `in_ready` = 0 only during that cycle.
- Ties: WINDOW = 8, feed 4× 8'h81 and 4× 8'h28 -> `out_data` = 8'h00, `out_tie` = 8'hA9.
- Backpressure: complete a window, hold `out_ready` = 0 for 10 cycles while `in_valid` = 1 -> `out_data` stable, `in_ready` = 0, no samples counted. Raise `out_ready` -> next window starts from zero counts.
- Clear: after 6 accepts, assert `clear` with `in_valid` = 1 -> that sample is dropped; the next 8 samples of 8'h04 yield `out_data` = 8'h04. A `clear` during HOLD drops `out_valid` next cycle.
- Async reset mid-window: assert `rst_n` low after 3 accepts, between clock edges -> outputs go to reset values immediately; a full subsequent window votes correctly.
